// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
//   Shared constants for the hardwired control sequencer: opcodes, FSM state
//   encoding, decode classes, FunSel codes for RF/ARF/IR, ALU function codes,
//   and the RF/ARF select encodings used on the datapath control bus.
package control_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_F0,
        ST_F1,
        ST_F2,
        ST_E0,
        ST_E1,
        ST_E2,
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_LDI,
        CLS_LD,
        CLS_ST,
        CLS_ALU,
        CLS_INC,
        CLS_DEC,
        CLS_BRA,
        CLS_BEQ,
        CLS_HLT
    } op_class_t;

    // Index of the final execute step of an instruction.
    typedef enum logic [1:0] {
        STEP_E0,
        STEP_E1,
        STEP_E2
    } exec_step_t;

    // Opcodes (IR[15:12])
    localparam logic [3:0] OP_LDI = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_LSL = 4'h9;
    localparam logic [3:0] OP_LSR = 4'hA;
    localparam logic [3:0] OP_INC = 4'hB;
    localparam logic [3:0] OP_DEC = 4'hC;
    localparam logic [3:0] OP_BRA = 4'hD;
    localparam logic [3:0] OP_BEQ = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // FunSel codes
    localparam logic [1:0] FS_CLEAR    = 2'b00;
    localparam logic [1:0] ARF_FS_LOAD = 2'b01;
    localparam logic [1:0] ARF_FS_INC  = 2'b10;
    localparam logic [1:0] RF_FS_LOAD  = 2'b01;
    localparam logic [1:0] RF_FS_DEC   = 2'b10;
    localparam logic [1:0] RF_FS_INC   = 2'b11;
    localparam logic [1:0] IR_FS_LOAD  = 2'b01;

    // ALU function codes
    localparam logic [3:0] ALU_PASS = 4'b0000;
    localparam logic [3:0] ALU_NOT  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_LSL  = 4'b1011;
    localparam logic [3:0] ALU_LSR  = 4'b1100;

    // ARF register selects and output selects
    localparam logic [3:0] ARF_SEL_PC = 4'b1000;
    localparam logic [3:0] ARF_SEL_AR = 4'b0100;
    localparam logic [1:0] ARF_OUT_AR = 2'b00;
    localparam logic [1:0] ARF_OUT_PC = 2'b11;

    // Mux selects
    localparam logic [1:0] MUXA_ALU = 2'b00;
    localparam logic [1:0] MUXA_MEM = 2'b01;
    localparam logic [1:0] MUXA_IMM = 2'b10;
    localparam logic [1:0] MUXB_IMM = 2'b10;
    localparam logic       MUXC_ALU = 1'b0;

    // R1..R4 map to one-hot 1000..0001.
    function automatic logic [3:0] rf_onehot(input logic [1:0] r);
        return 4'b1000 >> r;
    endfunction

    // RF read port select for R1..R4 is {1, reg}.
    function automatic logic [2:0] rf_rdsel(input logic [1:0] r);
        return {1'b1, r};
    endfunction

endpackage

// File: rtl/control_sequencer_op_decode.sv
// op_decode
//   Combinational opcode decoder.
//   opcode    : IR[15:12]
//   alu_fun   : ALU FunSel for the ALU class (ALU_PASS otherwise)
//   last_step : final execute step of the instruction
//   op_class  : instruction class driving the execute sequencing
module op_decode
    import control_sequencer_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [3:0] alu_fun,
    output exec_step_t last_step,
    output op_class_t  op_class
);

    always_comb begin
        alu_fun   = ALU_PASS;
        last_step = STEP_E0;
        op_class  = CLS_HLT;
        case (opcode)
            OP_LDI: op_class = CLS_LDI;
            OP_LD:  begin op_class = CLS_LD;  last_step = STEP_E1; end
            OP_ST:  begin op_class = CLS_ST;  last_step = STEP_E2; end
            OP_ADD: begin op_class = CLS_ALU; last_step = STEP_E2; alu_fun = ALU_ADD; end
            OP_SUB: begin op_class = CLS_ALU; last_step = STEP_E2; alu_fun = ALU_SUB; end
            OP_AND: begin op_class = CLS_ALU; last_step = STEP_E2; alu_fun = ALU_AND; end
            OP_OR:  begin op_class = CLS_ALU; last_step = STEP_E2; alu_fun = ALU_OR;  end
            OP_XOR: begin op_class = CLS_ALU; last_step = STEP_E2; alu_fun = ALU_XOR; end
            OP_NOT: begin op_class = CLS_ALU; last_step = STEP_E2; alu_fun = ALU_NOT; end
            OP_LSL: begin op_class = CLS_ALU; last_step = STEP_E2; alu_fun = ALU_LSL; end
            OP_LSR: begin op_class = CLS_ALU; last_step = STEP_E2; alu_fun = ALU_LSR; end
            OP_INC: op_class = CLS_INC;
            OP_DEC: op_class = CLS_DEC;
            OP_BRA: op_class = CLS_BRA;
            OP_BEQ: op_class = CLS_BEQ;
            default: op_class = CLS_HLT;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit for the 8-bit datapath. Fetches a 16-bit
//   instruction into IR over two memory reads (low byte, then high byte),
//   then sequences the execute steps. A private copy of the ALU flags is
//   captured by ALU-class instructions and used by BEQ.
//   Inputs : Clock, Reset (sync, active-low), IR_Out (current IR),
//            ALU_Flags {Z,C,N,O}
//   Outputs: RF / ARF / ALU / IR / memory / mux control fields (combinational
//            from state and IR), Halted (high in HALT)
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IR_Out,
    input  logic [3:0]  ALU_Flags,
    output logic [2:0]  RF_O1Sel,
    output logic [2:0]  RF_O2Sel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutASel,
    output logic [1:0]  ARF_OutBSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_FunSel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted
);

    state_t     state;
    logic [3:0] flags_q;
    logic [3:0] alu_fun;
    exec_step_t last_step;
    op_class_t  op_class;
    logic [1:0] rd;
    logic [1:0] rs;

    assign rd = IR_Out[11:10];
    assign rs = IR_Out[9:8];

    // The immediate reaches the datapath through MuxB/MuxA, not through here;
    // C/N/O are captured alongside Z but only Z steers a branch today.
    logic unused_bits;
    assign unused_bits = ^{IR_Out[7:0], flags_q[2:0]};

    op_decode u_op_decode (
        .opcode    (IR_Out[15:12]),
        .alu_fun   (alu_fun),
        .last_step (last_step),
        .op_class  (op_class)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state   <= ST_F0;
            flags_q <= 4'b0000;
        end else begin
            case (state)
                ST_F0: state <= ST_F1;
                ST_F1: state <= ST_F2;
                ST_F2: state <= ST_E0;
                ST_E0: begin
                    if (op_class == CLS_HLT)
                        state <= ST_HALT;
                    else if (last_step == STEP_E0)
                        state <= ST_F0;
                    else
                        state <= ST_E1;
                end
                ST_E1: state <= (last_step == STEP_E1) ? ST_F0 : ST_E2;
                ST_E2: begin
                    state <= ST_F0;
                    // ALU result (and its flags) is valid in E2.
                    if (op_class == CLS_ALU)
                        flags_q <= ALU_Flags;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_F0;
            endcase
        end
    end

    always_comb begin
        RF_O1Sel    = 3'b000;
        RF_O2Sel    = 3'b000;
        RF_FunSel   = FS_CLEAR;
        RF_RSel     = 4'b0000;
        RF_TSel     = 4'b0000;
        ALU_FunSel  = ALU_PASS;
        ARF_OutASel = 2'b00;
        ARF_OutBSel = ARF_OUT_PC;
        ARF_FunSel  = FS_CLEAR;
        ARF_RSel    = 4'b0000;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_FunSel   = FS_CLEAR;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        Halted      = 1'b0;

        if (!Reset) begin
            // Clear-all: every register enabled with FunSel = clear.
            RF_RSel   = 4'b1111;
            RF_TSel   = 4'b1111;
            ARF_RSel  = 4'b1111;
            IR_Enable = 1'b1;
        end else begin
            case (state)
                ST_F1, ST_F2: begin
                    Mem_CS     = 1'b0;
                    IR_Enable  = 1'b1;
                    IR_FunSel  = IR_FS_LOAD;
                    IR_LH      = (state == ST_F2);
                    ARF_FunSel = ARF_FS_INC;
                    ARF_RSel   = ARF_SEL_PC;
                end
                ST_E0: begin
                    case (op_class)
                        CLS_LDI: begin
                            MuxASel   = MUXA_IMM;
                            RF_FunSel = RF_FS_LOAD;
                            RF_RSel   = rf_onehot(rd);
                        end
                        CLS_LD, CLS_ST: begin
                            MuxBSel     = MUXB_IMM;
                            ARF_FunSel  = ARF_FS_LOAD;
                            ARF_RSel    = ARF_SEL_AR;
                            ARF_OutBSel = ARF_OUT_AR;
                            // ST routes Rd through the ALU next step.
                            if (op_class == CLS_ST)
                                RF_O1Sel = rf_rdsel(rd);
                        end
                        CLS_ALU: begin
                            RF_O1Sel = rf_rdsel(rd);
                            RF_O2Sel = rf_rdsel(rs);
                        end
                        CLS_INC: begin
                            RF_FunSel = RF_FS_INC;
                            RF_RSel   = rf_onehot(rd);
                        end
                        CLS_DEC: begin
                            RF_FunSel = RF_FS_DEC;
                            RF_RSel   = rf_onehot(rd);
                        end
                        CLS_BRA, CLS_BEQ: begin
                            if (op_class == CLS_BRA || flags_q[3]) begin
                                MuxBSel    = MUXB_IMM;
                                ARF_FunSel = ARF_FS_LOAD;
                                ARF_RSel   = ARF_SEL_PC;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_E1: begin
                    case (op_class)
                        CLS_LD: begin
                            Mem_CS    = 1'b0;
                            MuxASel   = MUXA_MEM;
                            RF_FunSel = RF_FS_LOAD;
                            RF_RSel   = rf_onehot(rd);
                        end
                        CLS_ST: begin
                            MuxCSel     = MUXC_ALU;
                            ALU_FunSel  = ALU_PASS;
                            ARF_OutBSel = ARF_OUT_AR;
                        end
                        CLS_ALU: begin
                            ALU_FunSel = alu_fun;
                            MuxCSel    = MUXC_ALU;
                        end
                        default: ;
                    endcase
                end
                ST_E2: begin
                    case (op_class)
                        CLS_ST: begin
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b1;
                            ARF_OutBSel = ARF_OUT_AR;
                        end
                        CLS_ALU: begin
                            MuxASel   = MUXA_ALU;
                            RF_FunSel = RF_FS_LOAD;
                            RF_RSel   = rf_onehot(rd);
                        end
                        default: ;
                    endcase
                end
                ST_HALT: Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    typedef struct packed {
        logic [2:0] o1;
        logic [2:0] o2;
        logic [1:0] rf_fs;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [3:0] alu;
        logic [1:0] outa;
        logic [1:0] outb;
        logic [1:0] arf_fs;
        logic [3:0] arf_rsel;
        logic       ir_lh;
        logic       ir_en;
        logic [1:0] ir_fs;
        logic       wr;
        logic       cs;
        logic [1:0] ma;
        logic [1:0] mb;
        logic       mc;
        logic       halted;
    } ctl_t;

    // step: 0..2 fetch, 3..5 execute, 8 halt, 9 reset
    typedef struct packed {
        ctl_t       ctl;
        logic [3:0] op;
        logic [3:0] step;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] IR_Out = 16'h0000;
    logic [3:0]  ALU_Flags = 4'h0;
    logic [2:0]  RF_O1Sel, RF_O2Sel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel, ARF_RSel;
    logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel, IR_FunSel, MuxASel, MuxBSel;
    logic        IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, Halted;

    always #5 Clock = ~Clock;

    control_sequencer dut (
        .Clock(Clock), .Reset(Reset), .IR_Out(IR_Out), .ALU_Flags(ALU_Flags),
        .RF_O1Sel(RF_O1Sel), .RF_O2Sel(RF_O2Sel), .RF_FunSel(RF_FunSel),
        .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
        .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel),
        .ARF_FunSel(ARF_FunSel), .ARF_RSel(ARF_RSel), .IR_LH(IR_LH),
        .IR_Enable(IR_Enable), .IR_FunSel(IR_FunSel), .Mem_WR(Mem_WR),
        .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
        .MuxCSel(MuxCSel), .Halted(Halted)
    );

    ctl_t got;
    assign got = {RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
                  ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel, IR_LH, IR_Enable,
                  IR_FunSel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel, Halted};

    // Reference tables: execute-step count per opcode, ALU code per opcode,
    // and one-hot destination select per register number.
    int         exec_len [16] = '{1, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 1, 1, 1, 1, 1};
    logic [3:0] alu_code [16] = '{4'h0, 4'h0, 4'h0, 4'b0100, 4'b0101, 4'b0111, 4'b1000,
                                  4'b1010, 4'b0010, 4'b1011, 4'b1100, 4'h0, 4'h0, 4'h0,
                                  4'h0, 4'h0};
    logic [3:0] rsel_of [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic z_model = 1'b0;
    logic done = 1'b0;
    logic final_done = 1'b0;

    function automatic ctl_t idle_w();
        ctl_t c;
        c = '0;
        c.outb = 2'b11;
        c.cs = 1'b1;
        return c;
    endfunction

    function automatic ctl_t reset_w();
        ctl_t c;
        c = idle_w();
        c.rf_rsel = 4'hF;
        c.rf_tsel = 4'hF;
        c.arf_rsel = 4'hF;
        c.ir_en = 1'b1;
        return c;
    endfunction

    function automatic ctl_t halt_w();
        ctl_t c;
        c = idle_w();
        c.halted = 1'b1;
        return c;
    endfunction

    function automatic ctl_t fetch_w(input int k);
        ctl_t c;
        c = idle_w();
        if (k == 1 || k == 2) begin
            c.cs = 1'b0;
            c.ir_en = 1'b1;
            c.ir_fs = 2'b01;
            c.ir_lh = (k == 2);
            c.arf_fs = 2'b10;
            c.arf_rsel = 4'b1000;
        end
        return c;
    endfunction

    function automatic ctl_t exec_w(input logic [3:0] op, input logic [1:0] rd,
                                    input logic [1:0] rs, input logic z, input int s);
        ctl_t c;
        c = idle_w();
        if (op == 4'h0) begin
            c.ma = 2'b10; c.rf_fs = 2'b01; c.rf_rsel = rsel_of[rd];
        end else if (op == 4'h1 || op == 4'h2) begin
            if (s == 0) begin
                c.mb = 2'b10; c.arf_fs = 2'b01; c.arf_rsel = 4'b0100; c.outb = 2'b00;
                if (op == 4'h2) c.o1 = {1'b1, rd};
            end else if (op == 4'h1) begin
                c.cs = 1'b0; c.ma = 2'b01; c.rf_fs = 2'b01; c.rf_rsel = rsel_of[rd];
            end else if (s == 1) begin
                c.outb = 2'b00;
            end else begin
                c.cs = 1'b0; c.wr = 1'b1; c.outb = 2'b00;
            end
        end else if (op >= 4'h3 && op <= 4'hA) begin
            if (s == 0) begin
                c.o1 = {1'b1, rd}; c.o2 = {1'b1, rs};
            end else if (s == 1) begin
                c.alu = alu_code[op];
            end else begin
                c.rf_fs = 2'b01; c.rf_rsel = rsel_of[rd];
            end
        end else if (op == 4'hB || op == 4'hC) begin
            c.rf_fs = (op == 4'hB) ? 2'b11 : 2'b10; c.rf_rsel = rsel_of[rd];
        end else if (op == 4'hD || (op == 4'hE && z)) begin
            c.mb = 2'b10; c.arf_fs = 2'b01; c.arf_rsel = 4'b1000;
        end
        return c;
    endfunction

    task automatic run_cycle(input ctl_t c, input logic rst_n, input logic [15:0] ir,
                             input logic [3:0] fl, input logic [3:0] op, input logic [3:0] step);
        exp_t e;
        @(posedge Clock);
        #1;
        Reset = rst_n;
        IR_Out = ir;
        ALU_Flags = fl;
        e.ctl = c;
        e.op = op;
        e.step = step;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            run_cycle(reset_w(), 1'b0, 16'($urandom), 4'($urandom), 4'h0, 4'd9);
        z_model = 1'b0;
    endtask

    task automatic do_halt(input int n);
        for (int i = 0; i < n; i++)
            run_cycle(halt_w(), 1'b1, 16'($urandom), 4'($urandom), 4'hF, 4'd8);
    endtask

    // fl_e2 < 0: random flags in the ALU result cycle; trunc: cycle index at
    // which Reset is pulled low instead (-1 = never).
    task automatic do_instr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                            input logic [7:0] imm, input int fl_e2, input int trunc,
                            output bit truncated);
        logic [15:0] instr;
        logic [3:0]  fl;
        logic        z_next;
        int          len;
        instr = {op, rd, rs, imm};
        len = 3 + exec_len[op];
        z_next = z_model;
        truncated = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (k == trunc) begin
                do_reset(1);
                truncated = 1'b1;
                return;
            end
            fl = 4'($urandom);
            if (k == 5 && fl_e2 >= 0) fl = 4'(fl_e2);
            if (k < 3)
                run_cycle(fetch_w(k), 1'b1, 16'($urandom), fl, op, 4'(k));
            else
                run_cycle(exec_w(op, rd, rs, z_model, k - 3), 1'b1, instr, fl, op, 4'(k));
            if (k == 5 && op >= 4'h3 && op <= 4'hA) z_next = fl[3];
        end
        z_model = z_next;
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got !== e.ctl) begin
                errors++;
                $display("FAIL ctl op=%0h step=%0d got=%h exp=%h", e.op, e.step, got, e.ctl);
            end
        end else if (done && !final_done) begin
            checks++;
            final_done = 1'b1;
        end
    end

    initial begin
        bit tr;
        logic [3:0] op;
        int trunc;

        do_reset(2);
        do_instr(4'h0, 2'd0, 2'd0, 8'h05, -1, -1, tr);      // LDI R1,#05
        do_instr(4'h0, 2'd1, 2'd0, 8'hFB, -1, -1, tr);      // LDI R2,#FB
        do_instr(4'h3, 2'd0, 2'd1, 8'h00, 4'b1100, -1, tr); // ADD R1,R2 -> Z=1,C=1
        do_instr(4'hE, 2'd0, 2'd0, 8'h10, -1, -1, tr);      // BEQ taken
        do_instr(4'h0, 2'd0, 2'd0, 8'h01, -1, -1, tr);      // LDI R1,#01
        do_instr(4'h3, 2'd0, 2'd0, 8'h00, 4'b0000, -1, tr); // ADD R1,R1 -> Z=0
        do_instr(4'hE, 2'd0, 2'd0, 8'h10, -1, -1, tr);      // BEQ not taken
        do_instr(4'h0, 2'd2, 2'd0, 8'hA5, -1, -1, tr);      // LDI R3,#A5
        do_instr(4'h2, 2'd2, 2'd0, 8'h80, -1, -1, tr);      // ST R3,[80]
        do_instr(4'h1, 2'd3, 2'd0, 8'h80, -1, -1, tr);      // LD R4,[80]
        do_instr(4'hF, 2'd0, 2'd0, 8'h00, -1, -1, tr);      // HLT
        do_halt(20);
        do_reset(2);
        do_instr(4'hE, 2'd0, 2'd0, 8'h20, -1, -1, tr);      // BEQ after reset: Z=0

        for (int n = 0; n < 250; n++) begin
            op = 4'($urandom_range(0, 15));
            trunc = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 5)) : -1;
            do_instr(op, 2'($urandom), 2'($urandom), 8'($urandom), -1, trunc, tr);
            if (op == 4'hF && !tr) begin
                do_halt(int'($urandom_range(1, 6)));
                do_reset(int'($urandom_range(1, 2)));
            end
        end

        @(negedge Clock);
        #1;
        done = 1'b1;
        @(negedge Clock);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
